ysyx_24080014_lsu: RTL and testbench



---
 rtl/ysyx_24080014_lsu_if.sv | 40 ++++
 rtl/ysyx_24080014_lsu.sv | 150 +++++++++++++++
 tb/tb_ysyx_24080014_lsu.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_24080014_lsu_if.sv
// Bus between the LSU and its neighbours: execute-stage request, memory block
// word port, and write-back result. slave is the LSU side, master the environment.
interface ysyx_24080014_lsu_if;
    // Handshakes: a transfer happens on a posedge where valid and ready are both
    // high; valid, once raised, holds its payload until that edge.
    logic        in_valid;
    logic        in_ready;
    logic        in_load;
    logic        in_store;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic        mem_wen;
    logic        mem_ren;
    logic        mem_valid;
    logic [7:0]  mem_wmask;
    logic [31:0] mem_waddr;
    logic [31:0] mem_raddr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_err;

    modport slave (
        input  in_valid, in_load, in_store, in_funct3, in_addr, in_wdata,
        input  mem_ready, mem_rdata, out_ready,
        output in_ready, mem_wen, mem_ren, mem_valid, mem_wmask, mem_waddr,
        output mem_raddr, mem_wdata, out_valid, out_data, out_err
    );

    modport master (
        output in_valid, in_load, in_store, in_funct3, in_addr, in_wdata,
        output mem_ready, mem_rdata, out_ready,
        input  in_ready, mem_wen, mem_ren, mem_valid, mem_wmask, mem_waddr,
        input  mem_raddr, mem_wdata, out_valid, out_data, out_err
    );
endinterface

// File: rtl/ysyx_24080014_lsu.sv
// Load/store unit: one memory instruction at a time, word-granular memory port,
// byte-lane alignment and load extension, single result to write-back.
module ysyx_24080014_lsu #(
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    ysyx_24080014_lsu_if.slave    bus,
    output logic [1:0]            dbg_state
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]  state;
    logic        ld_q;
    logic        st_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] data_q;
    logic        err_q;
    logic [7:0]  cnt_q;

    logic        illegal_in;
    logic        misalign_in;
    logic [31:0] shifted;
    logic [31:0] load_val;
    logic        issue_st;
    logic        issue_ld;

    // Request classification works on the live inputs; only the IDLE capture uses it.
    always_comb begin
        illegal_in  = 1'b0;
        misalign_in = 1'b0;
        if (bus.in_load && bus.in_store)
            illegal_in = 1'b1;
        else if (bus.in_load)
            illegal_in = (bus.in_funct3 == 3'b011) || (bus.in_funct3 == 3'b110) ||
                         (bus.in_funct3 == 3'b111);
        else if (bus.in_store)
            illegal_in = (bus.in_funct3 > 3'b010);
        case (bus.in_funct3[1:0])
            2'b01:   misalign_in = bus.in_addr[0];
            2'b10:   misalign_in = (bus.in_addr[1:0] != 2'b00);
            default: misalign_in = 1'b0;
        endcase
    end

    always_comb begin
        shifted = bus.mem_rdata >> {addr_q[1:0], 3'b000};
        case (f3_q)
            3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
            3'b010:  load_val = shifted;
            3'b100:  load_val = {24'd0, shifted[7:0]};
            3'b101:  load_val = {16'd0, shifted[15:0]};
            default: load_val = 32'd0;
        endcase
    end

    // Memory port is decoded purely from registered state and operands.
    always_comb begin
        issue_st      = (state == ISSUE) && st_q;
        issue_ld      = (state == ISSUE) && ld_q;
        bus.mem_wen   = issue_st;
        bus.mem_ren   = issue_ld;
        bus.mem_valid = (state != ISSUE);
        bus.mem_waddr = issue_st ? {addr_q[31:2], 2'b00} : 32'd0;
        bus.mem_raddr = issue_ld ? {addr_q[31:2], 2'b00} : 32'd0;
        bus.mem_wdata = issue_st ? (wdata_q << {addr_q[1:0], 3'b000}) : 32'd0;
        bus.mem_wmask = 8'd0;
        if (issue_st) begin
            case (f3_q[1:0])
                2'b00:   bus.mem_wmask = 8'h01 << addr_q[1:0];
                2'b01:   bus.mem_wmask = 8'h03 << addr_q[1:0];
                default: bus.mem_wmask = 8'h0F;
            endcase
        end
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        bus.out_data  = data_q;
        bus.out_err   = err_q;
        dbg_state     = state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ld_q    <= 1'b0;
            st_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            data_q  <= 32'd0;
            err_q   <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        ld_q    <= bus.in_load;
                        st_q    <= bus.in_store;
                        f3_q    <= bus.in_funct3;
                        addr_q  <= bus.in_addr;
                        wdata_q <= bus.in_wdata;
                        cnt_q   <= 8'd0;
                        if (!bus.in_load && !bus.in_store) begin
                            data_q <= bus.in_addr;
                            err_q  <= 1'b0;
                            state  <= DONE;
                        end else if (illegal_in || misalign_in) begin
                            data_q <= 32'd0;
                            err_q  <= 1'b1;
                            state  <= DONE;
                        end else begin
                            data_q <= 32'd0;
                            err_q  <= 1'b0;
                            state  <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    cnt_q <= 8'd0;
                    state <= ld_q ? WAIT : DONE;
                end
                WAIT: begin
                    // A response on the final counted edge still beats the timeout.
                    if (bus.mem_ready) begin
                        data_q <= load_val;
                        err_q  <= 1'b0;
                        state  <= DONE;
                    end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                        data_q <= 32'd0;
                        err_q  <= 1'b1;
                        state  <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    if (bus.out_ready) state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_24080014_lsu.sv
// Bench for ysyx_24080014_lsu: directed test-plan cases, a mid-load reset, then
// random instructions checked against an arithmetic reference model.
module tb_ysyx_24080014_lsu;

    localparam int TB_TIMEOUT = 4;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;

    ysyx_24080014_lsu_if bus ();

    ysyx_24080014_lsu #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic        err;
        logic [31:0] data;
        logic [7:0]  mask;
        logic [31:0] wd;
        int          lat;
        logic        mem;
    } exp_t;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: sizes in bytes, offsets as arithmetic, extension by subtraction.
    function automatic exp_t model(input bit ld, input bit st, input bit [2:0] f3,
                                   input bit [31:0] addr, input bit [31:0] wd,
                                   input bit [31:0] rword, input int d);
        exp_t   e;
        int     size;
        int     off;
        bit     legal;
        longint v;
        e.err = 0; e.data = 0; e.mask = 0; e.wd = 0; e.lat = 1; e.mem = 0;
        off = int'(addr % 4);
        if (!ld && !st) begin
            e.data = addr;
            return e;
        end
        size = 1 << f3[1:0];
        if (ld && st)      legal = 0;
        else if (ld)       legal = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
        else               legal = (f3 <= 2);
        if (!legal || (off % size) != 0) begin
            e.err = 1;
            return e;
        end
        e.mem = 1;
        if (st) begin
            e.mask = 8'(((1 << size) - 1) << off);
            e.wd   = wd << (8 * off);
            e.lat  = 2;
            return e;
        end
        if (d > TB_TIMEOUT) begin
            e.err = 1;
            e.lat = 2 + TB_TIMEOUT;
            return e;
        end
        e.lat = 2 + d;
        v = longint'(rword) >> (8 * off);
        if (size < 4) begin
            v = v & ((longint'(1) << (8 * size)) - 1);
            if (f3 < 4 && v[8 * size - 1]) v = v - (longint'(1) << (8 * size));
        end
        e.data = v[31:0];
        return e;
    endfunction

    // driver: offers one instruction, plays the memory, then completes the write-back handshake
    task automatic run_op(input bit ld, input bit st, input bit [2:0] f3,
                          input bit [31:0] addr, input bit [31:0] wd, input bit [31:0] rword,
                          input int d, input int hold);
        exp_t        e;
        int          k, first_valid, ren_n, wen_n, both_n, mvlow_n, ren_cyc;
        logic [31:0] raddr_s, waddr_s, wdata_s, exp_data;
        logic [7:0]  wmask_s;
        e = model(ld, st, f3, addr, wd, rword, d);
        exp_q.push_back(e.data);
        @(negedge clk);
        check("in_ready_idle", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1; bus.in_load = ld; bus.in_store = st;
        bus.in_funct3 = f3; bus.in_addr = addr; bus.in_wdata = wd;
        @(negedge clk);
        bus.in_valid = 0; bus.in_load = 1'($urandom); bus.in_store = 1'($urandom);
        bus.in_funct3 = 3'($urandom); bus.in_addr = $urandom; bus.in_wdata = $urandom;
        first_valid = 0; ren_n = 0; wen_n = 0; both_n = 0; mvlow_n = 0; ren_cyc = 0;
        raddr_s = 0; waddr_s = 0; wdata_s = 0; wmask_s = 0; k = 0;
        while (first_valid == 0 && k < 40) begin
            k++;
            if (k > 1) @(negedge clk);
            if (bus.mem_ren) begin ren_n++; raddr_s = bus.mem_raddr; ren_cyc = k; end
            if (bus.mem_wen) begin
                wen_n++; waddr_s = bus.mem_waddr; wdata_s = bus.mem_wdata; wmask_s = bus.mem_wmask;
            end
            if (bus.mem_ren && bus.mem_wen) both_n++;
            if (!bus.mem_valid) mvlow_n++;
            if (bus.out_valid) first_valid = k;
            if (ld && !st) begin
                bus.mem_ready = (ren_cyc != 0 && k == ren_cyc + d);
                bus.mem_rdata = bus.mem_ready ? rword : $urandom;
            end else begin
                bus.mem_ready = 1'($urandom);
                bus.mem_rdata = $urandom;
            end
        end
        bus.mem_ready = 0;
        exp_data = exp_q.pop_front();
        check("latency", 32'(first_valid), 32'(e.lat));
        check("out_data", bus.out_data, exp_data);
        check("out_err", 32'(bus.out_err), 32'(e.err));
        check("ren_count", 32'(ren_n), 32'(e.mem && ld));
        check("wen_count", 32'(wen_n), 32'(e.mem && st));
        check("ren_wen_overlap", 32'(both_n), 32'd0);
        check("mem_valid_low", 32'(mvlow_n), 32'(e.mem));
        if (ren_n != 0) check("mem_raddr", raddr_s, {addr[31:2], 2'b00});
        if (wen_n != 0) begin
            check("mem_waddr", waddr_s, {addr[31:2], 2'b00});
            check("mem_wmask", 32'(wmask_s), 32'(e.mask));
            check("mem_wdata", wdata_s, e.wd);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(bus.out_valid), 32'd1);
            check("hold_data", bus.out_data, exp_data);
            check("hold_err", 32'(bus.out_err), 32'(e.err));
            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1;
        check("in_ready_at_handshake", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        bus.out_ready = 0;
        check("valid_after_handshake", 32'(bus.out_valid), 32'd0);
        check("ready_after_handshake", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        bus.in_valid = 0; bus.in_load = 0; bus.in_store = 0; bus.in_funct3 = 0;
        bus.in_addr = 0; bus.in_wdata = 0; bus.mem_ready = 0; bus.mem_rdata = 0;
        bus.out_ready = 0;
        rst = 1;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", bus.out_data, 32'd0);
        check("rst_out_err", 32'(bus.out_err), 32'd0);
        check("rst_mem_strobes", {bus.mem_wen, bus.mem_ren, bus.mem_valid}, 32'b001);
        check("rst_mem_wmask", 32'(bus.mem_wmask), 32'd0);
        check("rst_mem_addrs", bus.mem_waddr | bus.mem_raddr | bus.mem_wdata, 32'd0);
        rst = 0;

        run_op(1, 0, 3'b000, 32'h8000_0003, 32'h0, 32'h80FF_1234, 1, 0);   // LB
        run_op(1, 0, 3'b101, 32'h8000_0002, 32'h0, 32'hBEEF_0001, 1, 1);   // LHU
        run_op(1, 0, 3'b001, 32'h8000_0002, 32'h0, 32'hBEEF_0001, 2, 0);   // LH
        run_op(0, 1, 3'b000, 32'h8000_0001, 32'h0000_00AB, 32'h0, 1, 0);   // SB
        run_op(1, 0, 3'b010, 32'h8000_0002, 32'h0, 32'h1234_5678, 1, 0);   // LW misaligned
        run_op(0, 1, 3'b001, 32'h8000_0001, 32'hFFFF_FFFF, 32'h0, 1, 0);   // SH misaligned
        run_op(1, 0, 3'b010, 32'h8000_0010, 32'h0, 32'hCAFE_F00D, 100, 0); // never ready
        run_op(1, 0, 3'b010, 32'h8000_0014, 32'h0, 32'hCAFE_F00D, TB_TIMEOUT, 0); // last edge
        run_op(0, 0, 3'b000, 32'h1234_5678, 32'h0, 32'h0, 1, 5);           // pass-through
        run_op(1, 1, 3'b000, 32'h8000_0000, 32'h0, 32'h0, 1, 0);           // load and store
        run_op(1, 0, 3'b011, 32'h8000_0000, 32'h0, 32'h0, 1, 0);           // illegal load f3
        run_op(0, 1, 3'b100, 32'h8000_0000, 32'h0, 32'h0, 1, 0);           // illegal store f3
        run_op(0, 1, 3'b010, 32'h8000_0008, 32'hDEAD_BEEF, 32'h0, 1, 0);   // SW

        // reset while a load waits for memory
        @(negedge clk);
        bus.in_valid = 1; bus.in_load = 1; bus.in_store = 0;
        bus.in_funct3 = 3'b010; bus.in_addr = 32'h8000_0020;
        @(negedge clk);
        bus.in_valid = 0;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        check("rst_wait_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_wait_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_wait_mem_ren", 32'(bus.mem_ren), 32'd0);
        rst = 0;

        for (int n = 0; n < 60; n++) begin
            bit        ld, st;
            bit [2:0]  f3;
            bit [31:0] addr;
            int        kind;
            kind = $urandom_range(0, 9);
            ld   = (kind < 5) || (kind == 9);
            st   = (kind >= 5 && kind < 8) || (kind == 9);
            f3   = (kind == 8 || $urandom_range(0, 5) == 0) ? 3'($urandom)
                 : (ld && !st) ? ($urandom_range(0, 1) ? 3'($urandom_range(0, 2))
                                                        : 3'($urandom_range(4, 5)))
                 : 3'($urandom_range(0, 2));
            addr = 32'h8000_0000 | ($urandom & 32'h0000_FFFF);
            run_op(ld, st, f3, addr, $urandom, $urandom,
                   $urandom_range(1, TB_TIMEOUT + 2), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
